flag_cond_unit: RTL and testbench
=================================

# flag_cond_unit

Consumer side of the 8-bit ALU's result and flag outputs. It latches the ALU result and the Z/C/N/V flags into an architectural flag register on each issued operation. It evaluates 4-bit condition codes against those flags for the branch/select logic. It also provides a small LIFO so flags can be saved and restored around interrupts or subroutine calls.

## Interface
- DEPTH, 4, flag save-stack entries (power of two, 2..16)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- upd_valid  in  1  ALU operation completed; capture flags/result this cycle
- upd_flags  in  4  {z,c,n,v} from ALU (c = carry on add, borrow A<B on sub)
- upd_result  in  8  ALU result
- cond_valid  in  1  condition evaluation request
- cond_code  in  4  condition to evaluate
- push  in  1  save current flag register to stack
- pop  in  1  restore flag register from stack top
- flags  out  4  registered {z,c,n,v}
- result_q  out  8  registered last ALU result
- cond_out_valid  out  1  cond_taken is valid this cycle
- cond_taken  out  1  condition outcome
- stk_full  out  1  stack holds DEPTH entries
- stk_empty  out  1  stack holds 0 entries
- stk_err  out  1  sticky: illegal push (full) or pop (empty) attempted

## Operation
- Flag register next value (flags_next), in priority order:
  - pop with a legal stack access loads the stack top.
  - Otherwise upd_valid loads upd_flags.
  - Otherwise the register holds.
- result_q loads upd_result whenever upd_valid is high, including when a pop overrides the flag load.
- push and pop apply to the stack only:
  - push alone, when not full: write the current flags (pre-update value) at the stack pointer; the pointer increments.
  - pop alone, when not empty: the pointer decrements; the flag register loads that entry.
  - push and pop together, when not empty: swap. The flag register loads the top entry, and the top entry is overwritten with the old flags. The pointer is unchanged. This is legal when full.
  - push and pop together when empty: error, no state change.
  - Illegal push or pop: no stack or flag change from that request. upd_valid still applies. stk_err sets.
- stk_err clears only on reset.
- cond_taken is evaluated on flags_next, so an update or restore in the same cycle is forwarded:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI !C&!Z (unsigned A>B after sub)
  - 9 LS C|Z
  - 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 NV 0

## Timing
- Reset values: flags=0000, result_q=0x00, cond_out_valid=0, cond_taken=0, stk_empty=1, stk_full=0, stk_err=0, stack pointer=0. Stack contents are don't-care.
- flags and result_q update on the edge that samples upd_valid/pop, with 1-cycle latency.
- Condition evaluation:
  - cond_out_valid and cond_taken are registered, asserted on the edge after cond_valid.
  - cond_out_valid is a single-cycle pulse per request.
  - Back-to-back requests give back-to-back results.
- stk_full and stk_empty are registered and reflect the pointer after the edge.
- Reset asserted mid-operation clears all state immediately. Any pending cond result is lost, with no pulse after reset release.

## Configuration
- FLAG_STICKY_V_EN defined:
  - Adds input clr_sticky (1) and output v_sticky (1), reset value 0.
  - v_sticky sets on any edge where flags_next.v=1.
  - clr_sticky clears it; a set in the same cycle wins.
- Not defined: both ports are absent and there is no sticky logic.

## Test plan
- Reset, then idle:
  - Outputs as listed under Timing.
  - upd_valid with flags=0100, result=0x00, then cond_valid with code 2 (CS) → next cycle flags=0100, cond_out_valid=1, cond_taken=1.
- Same-cycle forward:
  - upd_valid flags=0000 together with cond_valid code 0 (EQ), after flags were 1000 → cond_taken=0.
  - Code 14 → 1; code 15 → 0.
- Signed compare:
  - Load flags n=1, v=1 → GE=1, LT=0, GT=1.
  - Load z=1 → LE=1, GT=0.
  - Load c=0, z=0 → HI=1, LS=0.
- Stack fill/drain with DEPTH=4:
  - Push 0001, 0010, 0100, 1000 (loading each via upd_valid between pushes) → stk_full=1.
  - 5th push → stk_err=1, stack unchanged.
  - Four pops restore 1000, 0100, 0010, 0001 in order → stk_empty=1.
  - 5th pop → flags unchanged.
- Simultaneous events:
  - push+pop with top=0011, flags=1100 → flags=0011, top=1100, pointer unchanged.
  - pop+upd_valid → flags take the stack top, result_q takes upd_result.
  - push+upd_valid → stack saves the old flags, register takes the new flags.
- With FLAG_STICKY_V_EN:
  - v=1 update → v_sticky=1; it stays 1 after v=0 updates.
  - clr_sticky with a v=1 update in the same cycle → stays 1.
  - clr_sticky alone → 0.

Source files
------------

// File: rtl/flag_cond_unit_if.sv
// Bus bundle between the ALU/branch side and flag_cond_unit.
// FLAG_STICKY_V_EN adds clr_sticky / v_sticky to the bundle.
interface flag_cond_unit_if;
  logic       upd_valid;
  logic [3:0] upd_flags;
  logic [7:0] upd_result;
  logic       cond_valid;
  logic [3:0] cond_code;
  logic       push;
  logic       pop;
  logic [3:0] flags;
  logic [7:0] result_q;
  logic       cond_out_valid;
  logic       cond_taken;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_err;
`ifdef FLAG_STICKY_V_EN
  logic       clr_sticky;
  logic       v_sticky;

  modport master (
    output upd_valid, upd_flags, upd_result, cond_valid, cond_code, push, pop, clr_sticky,
    input  flags, result_q, cond_out_valid, cond_taken, stk_full, stk_empty, stk_err, v_sticky
  );

  modport slave (
    input  upd_valid, upd_flags, upd_result, cond_valid, cond_code, push, pop, clr_sticky,
    output flags, result_q, cond_out_valid, cond_taken, stk_full, stk_empty, stk_err, v_sticky
  );
`else
  modport master (
    output upd_valid, upd_flags, upd_result, cond_valid, cond_code, push, pop,
    input  flags, result_q, cond_out_valid, cond_taken, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  upd_valid, upd_flags, upd_result, cond_valid, cond_code, push, pop,
    output flags, result_q, cond_out_valid, cond_taken, stk_full, stk_empty, stk_err
  );
`endif
endinterface

// File: rtl/flag_cond_unit.sv
// Architectural {z,c,n,v} flag register, condition evaluator and flag save LIFO.
// Optional sticky overflow flag is enabled with the FLAG_STICKY_V_EN macro.
module flag_cond_unit #(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  flag_cond_unit_if.slave bus
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTRW = IDXW + 1;
  localparam logic [PTRW-1:0] PTR_MAX = PTRW'(DEPTH);

  typedef enum logic [2:0] {
    STK_IDLE = 3'd0,
    STK_PUSH = 3'd1,
    STK_POP  = 3'd2,
    STK_SWAP = 3'd3,
    STK_ERR  = 3'd4
  } stk_op_e;

  // Flag bit order is {z,c,n,v}; codes 8/9 read C as the borrow of a subtract.
  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
    logic z;
    logic c;
    logic n;
    logic v;
    logic r;
    z = f[3];
    c = f[2];
    n = f[1];
    v = f[0];
    case (code)
      4'd0:    r = z;
      4'd1:    r = ~z;
      4'd2:    r = c;
      4'd3:    r = ~c;
      4'd4:    r = n;
      4'd5:    r = ~n;
      4'd6:    r = v;
      4'd7:    r = ~v;
      4'd8:    r = ~c & ~z;
      4'd9:    r = c | z;
      4'd10:   r = (n == v);
      4'd11:   r = (n != v);
      4'd12:   r = ~z & (n == v);
      4'd13:   r = z | (n != v);
      4'd14:   r = 1'b1;
      4'd15:   r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [3:0]      flags_q, flags_d;
  logic [7:0]      res_q, res_d;
  logic [PTRW-1:0] sp_q, sp_d;
  logic [3:0]      stk_q [DEPTH];
  logic            err_q, err_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            cov_q, cov_d;
  logic            ctk_q, ctk_d;

  stk_op_e         stk_op_s;
  logic            sp_empty_s;
  logic            sp_full_s;
  logic [IDXW-1:0] top_idx_s;
  logic [IDXW-1:0] wr_idx_s;
  logic            wr_en_s;

  assign sp_empty_s = (sp_q == {PTRW{1'b0}});
  assign sp_full_s  = (sp_q == PTR_MAX);
  assign top_idx_s  = IDXW'(sp_q - PTRW'(1));

  // Classify the push/pop request; illegal requests collapse to STK_ERR.
  always_comb begin
    stk_op_s = STK_IDLE;
    if (bus.push && bus.pop) begin
      if (sp_empty_s) begin
        stk_op_s = STK_ERR;
      end else begin
        stk_op_s = STK_SWAP;
      end
    end else if (bus.push) begin
      if (sp_full_s) begin
        stk_op_s = STK_ERR;
      end else begin
        stk_op_s = STK_PUSH;
      end
    end else if (bus.pop) begin
      if (sp_empty_s) begin
        stk_op_s = STK_ERR;
      end else begin
        stk_op_s = STK_POP;
      end
    end else begin
      stk_op_s = STK_IDLE;
    end
  end

  // Next-state for pointer, stack write port, flags, result and condition output.
  always_comb begin
    sp_d     = sp_q;
    wr_en_s  = 1'b0;
    wr_idx_s = top_idx_s;
    err_d    = err_q;
    case (stk_op_s)
      STK_PUSH: begin
        wr_en_s  = 1'b1;
        wr_idx_s = sp_q[IDXW-1:0];
        sp_d     = sp_q + PTRW'(1);
      end
      STK_POP: begin
        sp_d = sp_q - PTRW'(1);
      end
      STK_SWAP: begin
        wr_en_s  = 1'b1;
        wr_idx_s = top_idx_s;
      end
      STK_ERR: begin
        err_d = 1'b1;
      end
      STK_IDLE: begin
        sp_d = sp_q;
      end
      default: begin
        sp_d = sp_q;
      end
    endcase

    // A legal restore outranks the ALU update; result still follows upd_valid.
    if ((stk_op_s == STK_POP) || (stk_op_s == STK_SWAP)) begin
      flags_d = stk_q[top_idx_s];
    end else if (bus.upd_valid) begin
      flags_d = bus.upd_flags;
    end else begin
      flags_d = flags_q;
    end

    if (bus.upd_valid) begin
      res_d = bus.upd_result;
    end else begin
      res_d = res_q;
    end

    full_d  = (sp_d == PTR_MAX);
    empty_d = (sp_d == {PTRW{1'b0}});

    cov_d = bus.cond_valid;
    if (bus.cond_valid) begin
      ctk_d = cond_eval(bus.cond_code, flags_d);
    end else begin
      ctk_d = 1'b0;
    end
  end

  // Architectural state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
      res_q   <= 8'h00;
      sp_q    <= {PTRW{1'b0}};
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      cov_q   <= 1'b0;
      ctk_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      res_q   <= res_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      cov_q   <= cov_d;
      ctk_q   <= ctk_d;
    end
  end

  // Save-stack storage; always written with the pre-update flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= 4'b0000;
      end
    end else if (wr_en_s) begin
      stk_q[wr_idx_s] <= flags_q;
    end else begin
      stk_q[wr_idx_s] <= stk_q[wr_idx_s];
    end
  end

  assign bus.flags          = flags_q;
  assign bus.result_q       = res_q;
  assign bus.cond_out_valid = cov_q;
  assign bus.cond_taken     = ctk_q;
  assign bus.stk_full       = full_q;
  assign bus.stk_empty      = empty_q;
  assign bus.stk_err        = err_q;

`ifdef FLAG_STICKY_V_EN
  logic vs_q, vs_d;

  // Sticky overflow: a set in the same cycle as a clear wins.
  always_comb begin
    if (flags_d[0]) begin
      vs_d = 1'b1;
    end else if (bus.clr_sticky) begin
      vs_d = 1'b0;
    end else begin
      vs_d = vs_q;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
    end else begin
      vs_q <= vs_d;
    end
  end

  assign bus.v_sticky = vs_q;
`endif

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: reference model plus a queue of expected condition outcomes.
module tb_flag_cond_unit;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  flag_cond_unit_if bus_if ();

  flag_cond_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp;
  int         n_bad;
  bit         exp_q[$];
  logic [3:0] m_flags;
  logic [3:0] m_stk [DEPTH];
  int         m_sp;
  logic       m_err;
  logic [7:0] m_result;
  logic       m_vs;

  function automatic bit ref_cond(input logic [3:0] cc, input logic [3:0] f);
    bit z, c, n, v, r;
    {z, c, n, v} = f;
    case (cc[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = !c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return cc[0] ? !r : r;
  endfunction

  task automatic clear_inputs();
    bus_if.upd_valid  = 1'b0;
    bus_if.upd_flags  = 4'b0000;
    bus_if.upd_result = 8'h00;
    bus_if.cond_valid = 1'b0;
    bus_if.cond_code  = 4'd0;
    bus_if.push       = 1'b0;
    bus_if.pop        = 1'b0;
`ifdef FLAG_STICKY_V_EN
    bus_if.clr_sticky = 1'b0;
`endif
  endtask

  // One clock of stimulus; updates the model and queues the expected condition outcome.
  task automatic step(input bit uv, input logic [3:0] uf, input logic [7:0] ur,
                      input bit cv, input logic [3:0] cc, input bit ps, input bit pp, input bit cs);
    logic [3:0] nf;
    bit ld;
    @(negedge clk);
    bus_if.upd_valid  = uv;
    bus_if.upd_flags  = uf;
    bus_if.upd_result = ur;
    bus_if.cond_valid = cv;
    bus_if.cond_code  = cc;
    bus_if.push       = ps;
    bus_if.pop        = pp;
`ifdef FLAG_STICKY_V_EN
    bus_if.clr_sticky = cs;
`endif
    nf = m_flags;
    ld = 1'b0;
    if (ps && pp) begin
      if (m_sp > 0) begin
        nf = m_stk[m_sp-1];
        m_stk[m_sp-1] = m_flags;
        ld = 1'b1;
      end else m_err = 1'b1;
    end else if (ps) begin
      if (m_sp < DEPTH) begin
        m_stk[m_sp] = m_flags;
        m_sp++;
      end else m_err = 1'b1;
    end else if (pp) begin
      if (m_sp > 0) begin
        m_sp--;
        nf = m_stk[m_sp];
        ld = 1'b1;
      end else m_err = 1'b1;
    end
    if (!ld && uv) nf = uf;
    if (cv) exp_q.push_back(ref_cond(cc, nf));
    if (uv) m_result = ur;
    if (nf[0]) m_vs = 1'b1;
    else if (cs) m_vs = 1'b0;
    m_flags = nf;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic model_reset();
    m_flags = 4'b0000;
    m_sp = 0;
    m_err = 1'b0;
    m_result = 8'h00;
    m_vs = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 7;
    if (bus_if.flags !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got=%b want=0000", bus_if.flags); end
    if (bus_if.result_q !== 8'h00) begin n_bad++; $display("FAIL rst_result got=%h want=00", bus_if.result_q); end
    if (bus_if.cond_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cov got=%b want=0", bus_if.cond_out_valid); end
    if (bus_if.cond_taken !== 1'b0) begin n_bad++; $display("FAIL rst_taken got=%b want=0", bus_if.cond_taken); end
    if (bus_if.stk_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got=%b want=1", bus_if.stk_empty); end
    if (bus_if.stk_full !== 1'b0) begin n_bad++; $display("FAIL rst_full got=%b want=0", bus_if.stk_full); end
    if (bus_if.stk_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b want=0", bus_if.stk_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit e;
    step(1'b1, 4'b0100, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 8'h00, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    n_cmp += 2;
    if (bus_if.flags !== 4'b0100) begin n_bad++; $display("FAIL basic_flags got=%b want=0100", bus_if.flags); end
    if (bus_if.cond_out_valid !== 1'b1 || exp_q.size() == 0) begin
      n_bad++; $display("FAIL basic_cov got=%b want=1", bus_if.cond_out_valid);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus_if.cond_taken !== e || bus_if.cond_taken !== 1'b1) begin
        n_bad++; $display("FAIL basic_cs got=%b want=1", bus_if.cond_taken);
      end
    end
    step(1'b0, 4'b0000, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus_if.cond_out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse got=%b want=0", bus_if.cond_out_valid); end
  endtask

  task automatic test_forward();
    logic [3:0] codes [3];
    bit e;
    codes[0] = 4'd0; codes[1] = 4'd14; codes[2] = 4'd15;
    step(1'b1, 4'b1000, 8'h11, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(i == 0, 4'b0000, 8'h22, 1'b1, codes[i], 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus_if.cond_out_valid !== 1'b1 || exp_q.size() == 0) begin
        n_bad++; $display("FAIL fwd_cov code=%0d got=%b want=1", codes[i], bus_if.cond_out_valid);
      end else begin
        e = exp_q.pop_front();
        if (bus_if.cond_taken !== e) begin
          n_bad++; $display("FAIL fwd_taken code=%0d got=%b want=%b", codes[i], bus_if.cond_taken, e);
        end
      end
    end
  endtask

  task automatic test_signed();
    logic [3:0] ld_flags [3];
    logic [3:0] codes [6];
    bit e;
    ld_flags[0] = 4'b0011; ld_flags[1] = 4'b1000; ld_flags[2] = 4'b0000;
    codes[0] = 4'd10; codes[1] = 4'd11; codes[2] = 4'd12;
    codes[3] = 4'd13; codes[4] = 4'd8;  codes[5] = 4'd9;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, ld_flags[k], 8'h30, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
        step(1'b0, 4'b0000, 8'h00, 1'b1, codes[i], 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus_if.cond_out_valid !== 1'b1 || exp_q.size() == 0) begin
          n_bad++; $display("FAIL signed_cov code=%0d got=%b want=1", codes[i], bus_if.cond_out_valid);
        end else begin
          e = exp_q.pop_front();
          if (bus_if.cond_taken !== e) begin
            n_bad++; $display("FAIL signed_taken flags=%b code=%0d got=%b want=%b",
                              ld_flags[k], codes[i], bus_if.cond_taken, e);
          end
        end
      end
    end
  endtask

  task automatic test_stack();
    logic [3:0] pat [4];
    pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b0100; pat[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pat[i], 8'h40, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'b0000, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (bus_if.stk_full !== (i == 3)) begin n_bad++; $display("FAIL fill_full i=%0d got=%b want=%b", i, bus_if.stk_full, i == 3); end
    end
    n_cmp++;
    if (bus_if.stk_err !== 1'b0) begin n_bad++; $display("FAIL fill_err got=%b want=0", bus_if.stk_err); end
    step(1'b0, 4'b0000, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp += 3;
    if (bus_if.stk_err !== 1'b1) begin n_bad++; $display("FAIL over_err got=%b want=1", bus_if.stk_err); end
    if (bus_if.stk_full !== 1'b1) begin n_bad++; $display("FAIL over_full got=%b want=1", bus_if.stk_full); end
    if (bus_if.flags !== 4'b1000) begin n_bad++; $display("FAIL over_flags got=%b want=1000", bus_if.flags); end
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, 4'b0000, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      n_cmp += 2;
      if (bus_if.flags !== pat[i]) begin n_bad++; $display("FAIL drain_flags i=%0d got=%b want=%b", i, bus_if.flags, pat[i]); end
      if (bus_if.stk_empty !== (i == 0)) begin n_bad++; $display("FAIL drain_empty i=%0d got=%b want=%b", i, bus_if.stk_empty, i == 0); end
    end
    step(1'b0, 4'b0000, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    n_cmp += 2;
    if (bus_if.flags !== 4'b0001) begin n_bad++; $display("FAIL under_flags got=%b want=0001", bus_if.flags); end
    if (bus_if.stk_empty !== 1'b1) begin n_bad++; $display("FAIL under_empty got=%b want=1", bus_if.stk_empty); end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 4'b0011, 8'h50, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1100, 8'h51, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    n_cmp += 3;
    if (bus_if.flags !== 4'b0011) begin n_bad++; $display("FAIL swap_flags got=%b want=0011", bus_if.flags); end
    if (bus_if.stk_empty !== 1'b0) begin n_bad++; $display("FAIL swap_empty got=%b want=0", bus_if.stk_empty); end
    if (bus_if.stk_full !== 1'b0) begin n_bad++; $display("FAIL swap_full got=%b want=0", bus_if.stk_full); end
    step(1'b0, 4'b0000, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    n_cmp += 2;
    if (bus_if.flags !== 4'b1100) begin n_bad++; $display("FAIL swap_top got=%b want=1100", bus_if.flags); end
    if (bus_if.stk_empty !== 1'b1) begin n_bad++; $display("FAIL swap_ptr got=%b want=1", bus_if.stk_empty); end
    step(1'b1, 4'b0101, 8'h52, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 8'hAB, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    n_cmp += 2;
    if (bus_if.flags !== 4'b0101) begin n_bad++; $display("FAIL popupd_flags got=%b want=0101", bus_if.flags); end
    if (bus_if.result_q !== 8'hAB) begin n_bad++; $display("FAIL popupd_result got=%h want=ab", bus_if.result_q); end
    step(1'b1, 4'b0110, 8'hCD, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus_if.flags !== 4'b0110) begin n_bad++; $display("FAIL pushupd_flags got=%b want=0110", bus_if.flags); end
    step(1'b0, 4'b0000, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (bus_if.flags !== 4'b0101) begin n_bad++; $display("FAIL pushupd_saved got=%b want=0101", bus_if.flags); end
  endtask

  task automatic test_back_to_back();
    bit e;
    for (int i = 0; i < 24; i++) begin
      step($urandom_range(0, 1), 4'($urandom), 8'($urandom), 1'b1, 4'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b0);
      n_cmp += 3;
      if (bus_if.flags !== m_flags) begin n_bad++; $display("FAIL b2b_flags i=%0d got=%b want=%b", i, bus_if.flags, m_flags); end
      if (bus_if.result_q !== m_result) begin n_bad++; $display("FAIL b2b_result i=%0d got=%h want=%h", i, bus_if.result_q, m_result); end
      if (bus_if.cond_out_valid !== 1'b1 || exp_q.size() == 0) begin
        n_bad++; $display("FAIL b2b_cov i=%0d got=%b want=1", i, bus_if.cond_out_valid);
      end else begin
        e = exp_q.pop_front();
        if (bus_if.cond_taken !== e) begin n_bad++; $display("FAIL b2b_taken i=%0d got=%b want=%b", i, bus_if.cond_taken, e); end
      end
    end
    step(1'b0, 4'b0000, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    n_cmp += 4;
    if (bus_if.cond_out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got=%b want=0", bus_if.cond_out_valid); end
    if (bus_if.stk_err !== m_err) begin n_bad++; $display("FAIL b2b_err got=%b want=%b", bus_if.stk_err, m_err); end
    if (bus_if.stk_empty !== (m_sp == 0)) begin n_bad++; $display("FAIL b2b_empty got=%b want=%b", bus_if.stk_empty, m_sp == 0); end
    if (bus_if.stk_full !== (m_sp == DEPTH)) begin n_bad++; $display("FAIL b2b_full got=%b want=%b", bus_if.stk_full, m_sp == DEPTH); end
  endtask

`ifdef FLAG_STICKY_V_EN
  task automatic test_sticky();
    step(1'b1, 4'b0001, 8'h60, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus_if.v_sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_set got=%b want=1", bus_if.v_sticky); end
    step(1'b1, 4'b0000, 8'h61, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 8'h62, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus_if.v_sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_hold got=%b want=1", bus_if.v_sticky); end
    step(1'b1, 4'b0001, 8'h63, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (bus_if.v_sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_setwins got=%b want=1", bus_if.v_sticky); end
    step(1'b1, 4'b0000, 8'h64, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    n_cmp += 2;
    if (bus_if.v_sticky !== 1'b0) begin n_bad++; $display("FAIL sticky_clr got=%b want=0", bus_if.v_sticky); end
    if (bus_if.v_sticky !== m_vs) begin n_bad++; $display("FAIL sticky_model got=%b want=%b", bus_if.v_sticky, m_vs); end
  endtask
`endif

  task automatic test_reset_mid();
    step(1'b1, 4'b1010, 8'h70, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus_if.cond_valid = 1'b1;
    bus_if.cond_code  = 4'd14;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus_if.cond_out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_cov got=%b want=0", bus_if.cond_out_valid); end
    @(negedge clk);
    clear_inputs();
    model_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp += 5;
    if (bus_if.cond_out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_nopulse got=%b want=0", bus_if.cond_out_valid); end
    if (bus_if.flags !== 4'b0000) begin n_bad++; $display("FAIL midrst_flags got=%b want=0000", bus_if.flags); end
    if (bus_if.result_q !== 8'h00) begin n_bad++; $display("FAIL midrst_result got=%h want=00", bus_if.result_q); end
    if (bus_if.stk_err !== 1'b0) begin n_bad++; $display("FAIL midrst_err got=%b want=0", bus_if.stk_err); end
    if (bus_if.stk_empty !== 1'b1) begin n_bad++; $display("FAIL midrst_empty got=%b want=1", bus_if.stk_empty); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_forward();
    test_signed();
    test_stack();
    test_simultaneous();
    test_back_to_back();
`ifdef FLAG_STICKY_V_EN
    test_sticky();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
